prach_diffft2: RTL and testbench

- Radix-2 decimation-in-frequency FFT/IFFT stage for the PRACH long-format chain. It is the counterpart of the DIT stage: butterfly first, then twiddle multiply.
- Single-path delay-feedback (SDF) architecture over frames of N = 2^NUM_FFT_LENGTH complex samples.
- Consumes and produces the chain's standard stream: dr/di, dv, sync, dv_ahead, sync_ahead.

---
 rtl/prach_diffft2.sv | 186 ++++++++++++++++++
 tb/tb_prach_diffft2.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prach_diffft2.sv
// Radix-2 DIF single-path delay-feedback stage for the PRACH chain.
// The butterfly runs at the input; the twiddle multiply follows it, and a matched bypass carries the sums.
module prach_diffft2 #(
  parameter int NUM_FFT_LENGTH = 6,
  parameter bit INVERSE        = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] din_dr,
  input  logic [17:0] din_di,
  input  logic        din_dv,
  input  logic        sync_in,
  input  logic        din_dv_ahead,
  input  logic        sync_ahead_in,
  output logic [17:0] dout_dr,
  output logic [17:0] dout_di,
  output logic        dout_dv,
  output logic        sync_out,
  output logic        dout_dv_ahead,
  output logic        sync_ahead_out,
  output logic        sync_err
);

  localparam int  N    = 1 << NUM_FFT_LENGTH;
  localparam int  HALF = N / 2;
  localparam int  AW   = NUM_FFT_LENGTH - 1;
  localparam real PI   = 3.14159265358979323846;

  function automatic logic signed [17:0] sat18(input logic signed [37:0] x);
    if (x > 38'sd131071) return 18'h1FFFF;
    if (x < -38'sd131072) return 18'h20000;
    return x[17:0];
  endfunction

  // Halve a 19-bit sum/difference with round-half-up, then clamp back to 18 bits.
  function automatic logic signed [17:0] half_rnd(input logic signed [17:0] x,
                                                   input logic signed [17:0] y,
                                                   input logic sub);
    logic signed [19:0] t;
    t = sub ? (20'(x) - 20'(y)) : (20'(x) + 20'(y));
    return sat18(38'((t + 20'sd1) >>> 1));
  endfunction

  function automatic logic [35:0] tw_entry(input int j);
    real ang;
    logic signed [17:0] c;
    logic signed [17:0] s;
    ang = 2.0 * PI * real'(j) / real'(N);
    c = 18'($rtoi($floor($cos(ang) * 65536.0 + 0.5)));
    s = 18'($rtoi($floor($sin(ang) * 65536.0 + 0.5)));
    if (!INVERSE) s = -s;
    return {c, s};
  endfunction

  logic [35:0] tw_rom [HALF];
  for (genvar g = 0; g < HALF; g++) begin : g_rom
    assign tw_rom[g] = tw_entry(g);
  end

  // ---------------- front end: counter, pending flag, delay memory, butterfly
  logic [NUM_FFT_LENGTH-1:0] k;
  logic [NUM_FFT_LENGTH-1:0] k_eff;
  logic                      pending;
  logic                      early;
  logic                      phase_b;
  logic                      last_in_half;
  logic [AW-1:0]             addr;
  logic [35:0]               mem [HALF];
  logic signed [17:0]        m_re;
  logic signed [17:0]        m_im;
  logic signed [17:0]        s_re;
  logic signed [17:0]        s_im;
  logic signed [17:0]        d_re;
  logic signed [17:0]        d_im;
  logic                      st_dv;
  logic                      st_sync;
  logic signed [17:0]        st_re;
  logic signed [17:0]        st_im;

  always_comb begin
    k_eff        = (din_dv && sync_in) ? '0 : k;
    early        = din_dv && sync_in && (k != '0);
    addr         = k_eff[AW-1:0];
    phase_b      = k_eff[NUM_FFT_LENGTH-1];
    last_in_half = &addr;
    m_re         = mem[addr][35:18];
    m_im         = mem[addr][17:0];
    s_re         = half_rnd(m_re, din_dr, 1'b0);
    s_im         = half_rnd(m_im, din_di, 1'b0);
    d_re         = half_rnd(m_re, din_dr, 1'b1);
    d_im         = half_rnd(m_im, din_di, 1'b1);
    // First half emits the stored differences of the previous frame; an early sync voids them.
    st_dv        = din_dv && (phase_b || (pending && !early));
    st_sync      = din_dv && phase_b && (addr == '0);
    st_re        = phase_b ? s_re : m_re;
    st_im        = phase_b ? s_im : m_im;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k       <= '0;
      pending <= 1'b0;
    end else if (din_dv) begin
      k <= k_eff + NUM_FFT_LENGTH'(1);
      if (early) pending <= 1'b0;
      else if (last_in_half) pending <= phase_b;
    end
  end

  // Read-before-write on the same address: phase A reads the old difference, then stores a[k].
  always_ff @(posedge clk) begin
    if (!rst && din_dv) mem[addr] <= phase_b ? {d_re, d_im} : {din_dr, din_di};
  end

  // ---------------- pipeline: s1 capture, s2 ROM, s3 products, s4 add/sub, s5 round, output
  logic [4:0]         dv_p;
  logic [4:0]         sync_p;
  logic [4:0]         err_p;
  logic [4:0]         tw_p;
  logic [5:0]         ahd_dv;
  logic [5:0]         ahd_sync;
  logic signed [17:0] byp_re [5];
  logic signed [17:0] byp_im [5];
  logic [AW-1:0]      j1;
  logic signed [17:0] w_re2;
  logic signed [17:0] w_im2;
  logic signed [35:0] p_rr;
  logic signed [35:0] p_ii;
  logic signed [35:0] p_ri;
  logic signed [35:0] p_ir;
  logic signed [36:0] acc_re;
  logic signed [36:0] acc_im;
  logic signed [17:0] tw_re5;
  logic signed [17:0] tw_im5;

  always_ff @(posedge clk) begin
    if (rst) begin
      dv_p     <= '0;
      sync_p   <= '0;
      err_p    <= '0;
      tw_p     <= '0;
      ahd_dv   <= '0;
      ahd_sync <= '0;
      dout_dv  <= 1'b0;
      sync_out <= 1'b0;
      sync_err <= 1'b0;
      dout_dr  <= '0;
      dout_di  <= '0;
    end else begin
      dv_p     <= {dv_p[3:0], st_dv};
      sync_p   <= {sync_p[3:0], st_sync};
      err_p    <= {err_p[3:0], early};
      tw_p     <= {tw_p[3:0], !phase_b};
      ahd_dv   <= {ahd_dv[4:0], din_dv_ahead};
      ahd_sync <= {ahd_sync[4:0], sync_ahead_in};
      dout_dv  <= dv_p[4];
      sync_out <= sync_p[4];
      sync_err <= err_p[4];
      dout_dr  <= dv_p[4] ? (tw_p[4] ? tw_re5 : byp_re[4]) : '0;
      dout_di  <= dv_p[4] ? (tw_p[4] ? tw_im5 : byp_im[4]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    byp_re[0] <= st_re;
    byp_im[0] <= st_im;
    for (int i = 1; i < 5; i++) begin
      byp_re[i] <= byp_re[i-1];
      byp_im[i] <= byp_im[i-1];
    end
    j1             <= addr;
    {w_re2, w_im2} <= tw_rom[j1];
    p_rr           <= byp_re[1] * w_re2;
    p_ii           <= byp_im[1] * w_im2;
    p_ri           <= byp_re[1] * w_im2;
    p_ir           <= byp_im[1] * w_re2;
    acc_re         <= 37'(p_rr) - 37'(p_ii);
    acc_im         <= 37'(p_ri) + 37'(p_ir);
    tw_re5         <= sat18((38'(acc_re) + 38'sd32768) >>> 16);
    tw_im5         <= sat18((38'(acc_im) + 38'sd32768) >>> 16);
  end

  assign dout_dv_ahead  = ahd_dv[5];
  assign sync_ahead_out = ahd_sync[5];

endmodule

// File: tb/tb_prach_diffft2.sv
// Bench for prach_diffft2 at N=8: a forward and an inverse instance share one stimulus stream,
// and a frame-level reference model predicts every output cycle of both.
module tb_prach_diffft2;

  localparam int  L    = 3;
  localparam int  N    = 8;
  localparam int  HALF = 4;
  localparam int  W    = 78;
  localparam real PI   = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] din_dr = '0;
  logic [17:0] din_di = '0;
  logic        din_dv = 1'b0;
  logic        sync_in = 1'b0;
  logic        din_dv_ahead = 1'b0;
  logic        sync_ahead_in = 1'b0;

  logic [17:0] dout_dr, dout_di, dout_dr_i, dout_di_i;
  logic        dout_dv, sync_out, dout_dv_ahead, sync_ahead_out, sync_err;
  logic        dout_dv_i, sync_out_i, dout_dv_ahead_i, sync_ahead_out_i, sync_err_i;

  always #5 clk = ~clk;

  prach_diffft2 #(.NUM_FFT_LENGTH(L), .INVERSE(1'b0)) dut (
    .clk(clk), .rst(rst), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
    .sync_in(sync_in), .din_dv_ahead(din_dv_ahead), .sync_ahead_in(sync_ahead_in),
    .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv), .sync_out(sync_out),
    .dout_dv_ahead(dout_dv_ahead), .sync_ahead_out(sync_ahead_out), .sync_err(sync_err)
  );

  prach_diffft2 #(.NUM_FFT_LENGTH(L), .INVERSE(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
    .sync_in(sync_in), .din_dv_ahead(din_dv_ahead), .sync_ahead_in(sync_ahead_in),
    .dout_dr(dout_dr_i), .dout_di(dout_di_i), .dout_dv(dout_dv_i), .sync_out(sync_out_i),
    .dout_dv_ahead(dout_dv_ahead_i), .sync_ahead_out(sync_ahead_out_i), .sync_err(sync_err_i)
  );

  // ---------------- reference model
  int          vectors = 0;
  int          miscompares = 0;
  int          fail_prints = 0;
  logic [W-1:0] exp_q[$];
  int          mk = 0;
  bit          mpend = 1'b0;
  longint      ar [N];
  longint      ai [N];
  longint      dr_ [HALF];
  longint      di_ [HALF];

  function automatic logic signed [17:0] sat(input longint x);
    if (x > 131071) return 18'sh1FFFF;
    if (x < -131072) return 18'sh20000;
    return 18'(x);
  endfunction

  function automatic logic signed [17:0] half(input longint a, input longint b, input bit sub);
    return sat(((sub ? a - b : a + b) + 1) >>> 1);
  endfunction

  task automatic cmul(input longint dr, input longint di, input int j, input bit inv,
                      output logic signed [17:0] yr, output logic signed [17:0] yi);
    real ang;
    longint wr, wi;
    ang = 2.0 * PI * real'(j) / real'(N);
    wr = longint'($floor($cos(ang) * 65536.0 + 0.5));
    wi = longint'($floor($sin(ang) * 65536.0 + 0.5));
    if (!inv) wi = -wi;
    yr = sat((dr * wr - di * wi + 32768) >>> 16);
    yi = sat((dr * wi + di * wr + 32768) >>> 16);
  endtask

  task automatic check_lit(input string nm, input longint got, input longint want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d", nm, got, want);
    end
  endtask

  function automatic logic [17:0] rnd_sample();
    case ($urandom_range(0, 3))
      0: return 18'h1FFFF;
      1: return 18'h20000;
      default: return 18'($urandom);
    endcase
  endfunction

  // Drives one cycle and queues what the outputs must be six cycles later.
  task automatic step(input logic r, input logic v, input logic s,
                      input logic [17:0] xr, input logic [17:0] xi);
    logic dva, sya, o_dv, o_sy, o_er;
    logic signed [17:0] o_re, o_im, o_rei, o_imi;
    int m;
    dva = 1'($urandom_range(0, 1));
    sya = 1'($urandom_range(0, 1));
    o_dv = 0; o_sy = 0; o_er = 0; o_re = 0; o_im = 0; o_rei = 0; o_imi = 0;
    @(posedge clk);
    #1;
    rst = r; din_dv = v; sync_in = s; din_dr = xr; din_di = xi;
    din_dv_ahead = dva; sync_ahead_in = sya;
    if (r) begin
      mk = 0;
      mpend = 1'b0;
      for (int i = 1; i < 6; i++) exp_q[i] = {1'b1, 77'b0};
      dva = 1'b0;
      sya = 1'b0;
    end else if (v) begin
      if (s && mk != 0) begin
        o_er = 1'b1;
        mpend = 1'b0;
      end
      if (s) mk = 0;
      ar[mk] = longint'($signed(xr));
      ai[mk] = longint'($signed(xi));
      if (mk < HALF) begin
        if (mpend) begin
          o_dv = 1'b1;
          cmul(dr_[mk], di_[mk], mk, 1'b0, o_re, o_im);
          cmul(dr_[mk], di_[mk], mk, 1'b1, o_rei, o_imi);
        end
        if (mk == HALF - 1) mpend = 1'b0;
      end else begin
        m = mk - HALF;
        o_dv = 1'b1;
        o_sy = (m == 0);
        o_re = half(ar[m], ar[mk], 1'b0);
        o_im = half(ai[m], ai[mk], 1'b0);
        o_rei = o_re;
        o_imi = o_im;
        if (mk == N - 1) begin
          for (int i = 0; i < HALF; i++) begin
            dr_[i] = half(ar[i], ar[i + HALF], 1'b1);
            di_[i] = half(ai[i], ai[i + HALF], 1'b1);
          end
          mpend = 1'b1;
        end
      end
      mk = (mk + 1) % N;
    end
    exp_q.push_back({1'b1, o_dv, o_sy, o_er, dva, sya, o_re, o_im, o_rei, o_imi});
  endtask

  // ---------------- per-cycle compare
  logic [W-1:0] ce;
  logic         bad;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ce = exp_q.pop_front();
      if (ce[77]) begin
        vectors++;
        bad = (dout_dv !== ce[76]) || (sync_out !== ce[75]) || (sync_err !== ce[74]) ||
              (dout_dv_ahead !== ce[73]) || (sync_ahead_out !== ce[72]) ||
              (dout_dv_i !== ce[76]) || (sync_out_i !== ce[75]) || (sync_err_i !== ce[74]) ||
              (dout_dv_ahead_i !== ce[73]) || (sync_ahead_out_i !== ce[72]);
        if (ce[76])
          bad = bad || (dout_dr !== ce[71:54]) || (dout_di !== ce[53:36]) ||
                (dout_dr_i !== ce[35:18]) || (dout_di_i !== ce[17:0]);
        if (bad) begin
          miscompares++;
          if (fail_prints < 30) begin
            fail_prints++;
            $display("FAIL slot t=%0t got dv=%b sy=%b er=%b dva=%b sya=%b re=%0d im=%0d ire=%0d iim=%0d | exp dv=%b sy=%b er=%b dva=%b sya=%b re=%0d im=%0d ire=%0d iim=%0d",
                     $time, dout_dv, sync_out, sync_err, dout_dv_ahead, sync_ahead_out,
                     $signed(dout_dr), $signed(dout_di), $signed(dout_dr_i), $signed(dout_di_i),
                     ce[76], ce[75], ce[74], ce[73], ce[72],
                     $signed(ce[71:54]), $signed(ce[53:36]), $signed(ce[35:18]), $signed(ce[17:0]));
          end
        end
      end
    end
  end

  // ---------------- directed frames
  task automatic impulse(input int p0, input logic [17:0] v0, input int p1, input logic [17:0] v1);
    for (int i = 0; i < N; i++)
      step(0, 1, (i == 0), (i == p0) ? v0 : ((i == p1) ? v1 : 18'h0), 18'h0);
    for (int i = 0; i < HALF; i++) step(0, 1, 0, rnd_sample(), rnd_sample());
    repeat (3) step(0, 0, 0, 18'h0, 18'h0);
  endtask

  logic signed [17:0] lr, li;
  logic v, s, r;

  initial begin
    for (int i = 0; i < 6; i++) exp_q.push_back('0);

    // Model pins against hand-computed values.
    cmul(500, 0, 1, 1'b0, lr, li);
    check_lit("tw_fwd_re", lr, 354);
    check_lit("tw_fwd_im", li, -354);
    cmul(500, 0, 1, 1'b1, lr, li);
    check_lit("tw_inv_re", lr, 354);
    check_lit("tw_inv_im", li, 354);
    cmul(-77, 1234, 0, 1'b0, lr, li);
    check_lit("tw_j0_re", lr, -77);
    check_lit("tw_j0_im", li, 1234);
    check_lit("half_sat", half(131071, -131072, 1'b1), 131071);
    check_lit("half_sum0", half(131071, -131072, 1'b0), 0);
    check_lit("half_imp", half(1000, 0, 1'b0), 500);
    check_lit("half_neg", half(0, 1000, 1'b1), -500);

    repeat (3) step(1, 0, 0, 18'h0, 18'h0);
    step(0, 0, 1, 18'h0, 18'h0);

    impulse(0, 18'd1000, -1, 18'h0);
    impulse(1, 18'd1000, -1, 18'h0);
    impulse(0, 18'h1FFFF, 4, 18'h20000);

    // Gapped DC frame and gapped flush.
    for (int i = 0; i < N; i++) begin
      step(0, 1, (i == 0), 18'd1000, 18'h0);
      step(0, 0, 0, 18'h0, 18'h0);
    end
    for (int i = 0; i < HALF; i++) begin
      step(0, 1, 0, 18'h0, 18'h0);
      step(0, 0, 0, 18'h0, 18'h0);
    end

    // Early sync at k=5, then a full frame.
    for (int i = 0; i < 5; i++) step(0, 1, (i == 0), rnd_sample(), rnd_sample());
    for (int i = 0; i < N; i++) step(0, 1, (i == 0), rnd_sample(), rnd_sample());
    for (int i = 0; i < HALF; i++) step(0, 1, 0, rnd_sample(), rnd_sample());
    repeat (2) step(0, 0, 0, 18'h0, 18'h0);

    // Reset mid-frame at k=6.
    for (int i = 0; i < 6; i++) step(0, 1, (i == 0), rnd_sample(), rnd_sample());
    step(1, 1, 0, rnd_sample(), rnd_sample());
    for (int i = 0; i < N; i++) step(0, 1, (i == 0), rnd_sample(), rnd_sample());
    for (int i = 0; i < HALF; i++) step(0, 1, 0, rnd_sample(), rnd_sample());

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      v = ($urandom_range(0, 99) < 75);
      if (mk == 0) s = ($urandom_range(0, 9) < 8);
      else s = ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 399) == 0);
      step(r, v, s, rnd_sample(), rnd_sample());
    end

    repeat (8) step(0, 0, 0, 18'h0, 18'h0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
